// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle RV32I subset core: opcodes, FSM states, ALU ops.
package core_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK_INST = 32'h00100073;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

    typedef enum logic [1:0] {ADD, SUB, PASSB} alu_op_t;

endpackage

// File: rtl/core_regfile.sv
// Architectural register file: two combinational read ports, a debug read port,
// one synchronous write port; x0 reads as zero and ignores writes.
module core_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    input  logic [AW-1:0]   i_dbg_addr,
    input  logic            i_we,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [XLEN-1:0] i_wr_data,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_dbg_data
);

    logic [XLEN-1:0] r_regs [NREGS];

    // Whole-file clear on reset rules out block RAM; this maps to flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wr_addr != '0)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rs1_data = (i_rs1_addr == '0) ? '0 : r_regs[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == '0) ? '0 : r_regs[i_rs2_addr];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I subset core (addi/add/sub/lui/auipc/jal/jalr/ebreak) with a
// FETCH/DECODE/EXEC/WB state machine and a req/rvalid instruction fetch.
module multi_cycle_core
    import core_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int          NREGS    = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            retire,
    output logic [XLEN-1:0] retire_pc,
    output logic            halt,
    output logic            trap,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    state_t          r_state, w_state_next;
    logic [XLEN-1:0] r_pc, r_op_a, r_op_b, r_tgt_base, r_tgt_off, r_result, r_target;
    logic [31:0]     r_ir;
    alu_op_t         r_alu_op;
    logic            r_is_jump, r_is_jalr, r_halt, r_trap;

    logic [6:0]      w_opcode, w_funct7;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm_i, w_imm_u, w_imm_j, w_rs1_data, w_rs2_data;
    logic [XLEN-1:0] w_op_a, w_op_b, w_tgt_base, w_tgt_off, w_alu_result;
    alu_op_t         w_alu_op;
    logic            w_is_jump, w_is_jalr, w_legal, w_is_ebreak;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_funct7 = r_ir[31:25];
    assign w_imm_i  = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_u  = {r_ir[31:12], 12'h000};
    assign w_imm_j  = {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_is_ebreak = (r_ir == EBREAK_INST);

    core_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_rs1_addr (r_ir[19:15]),
        .i_rs2_addr (r_ir[24:20]),
        .i_dbg_addr (dbg_addr),
        .i_we       (r_state == WB),
        .i_wr_addr  (r_ir[11:7]),
        .i_wr_data  (r_result),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .o_dbg_data (dbg_data)
    );

    // Only the funct3/funct7 combinations of the supported subset are legal.
    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            OP_IMM:            w_legal = (w_funct3 == 3'b000);
            OP:                w_legal = (w_funct3 == 3'b000) &&
                                         ((w_funct7 == 7'h00) || (w_funct7 == 7'h20));
            LUI, AUIPC, JAL:   w_legal = 1'b1;
            JALR:              w_legal = (w_funct3 == 3'b000);
            default:           w_legal = 1'b0;
        endcase
    end

    // Jumps reuse the ALU for the link value (pc + 4); the target has its own adder.
    always_comb begin
        w_op_a     = w_rs1_data;
        w_op_b     = w_imm_i;
        w_alu_op   = ADD;
        w_tgt_base = r_pc;
        w_tgt_off  = w_imm_j;
        w_is_jump  = 1'b0;
        w_is_jalr  = 1'b0;
        case (w_opcode)
            OP: begin
                w_op_b   = w_rs2_data;
                w_alu_op = w_funct7[5] ? SUB : ADD;
            end
            LUI: begin
                w_op_b   = w_imm_u;
                w_alu_op = PASSB;
            end
            AUIPC: begin
                w_op_a = r_pc;
                w_op_b = w_imm_u;
            end
            JAL: begin
                w_op_a    = r_pc;
                w_op_b    = XLEN'(4);
                w_is_jump = 1'b1;
            end
            JALR: begin
                w_op_a     = r_pc;
                w_op_b     = XLEN'(4);
                w_is_jump  = 1'b1;
                w_is_jalr  = 1'b1;
                w_tgt_base = w_rs1_data;
                w_tgt_off  = w_imm_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_alu_op)
            ADD:     w_alu_result = r_op_a + r_op_b;
            SUB:     w_alu_result = r_op_a - r_op_b;
            default: w_alu_result = r_op_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH:   if (imem_rvalid) w_state_next = DECODE;
            DECODE:  w_state_next = (w_is_ebreak || !w_legal) ? HALT : EXEC;
            EXEC:    w_state_next = WB;
            WB:      w_state_next = FETCH;
            HALT:    w_state_next = HALT;
            default: w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_alu_op   <= ADD;
            r_tgt_base <= '0;
            r_tgt_off  <= '0;
            r_is_jump  <= 1'b0;
            r_is_jalr  <= 1'b0;
            r_result   <= '0;
            r_target   <= '0;
            r_halt     <= 1'b0;
            r_trap     <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_rvalid) r_ir <= imem_rdata;
                end
                DECODE: begin
                    r_op_a     <= w_op_a;
                    r_op_b     <= w_op_b;
                    r_alu_op   <= w_alu_op;
                    r_tgt_base <= w_tgt_base;
                    r_tgt_off  <= w_tgt_off;
                    r_is_jump  <= w_is_jump;
                    r_is_jalr  <= w_is_jalr;
                    if (w_is_ebreak) begin
                        r_halt <= 1'b1;
                    end else if (!w_legal) begin
                        r_halt <= 1'b1;
                        r_trap <= 1'b1;
                    end
                end
                EXEC: begin
                    r_result <= w_alu_result;
                    r_target <= (r_tgt_base + r_tgt_off) & ~{{(XLEN-1){1'b0}}, r_is_jalr};
                end
                WB: begin
                    r_pc <= r_is_jump ? r_target : r_pc + XLEN'(4);
                end
                default: ;
            endcase
        end
    end

    assign imem_req  = (r_state == FETCH) && !rst;
    assign imem_addr = r_pc;
    assign retire    = (r_state == WB);
    assign retire_pc = r_pc;
    assign halt      = r_halt;
    assign trap      = r_trap;

endmodule

// File: tb/tb_multi_cycle_core.sv
// Self-checking bench for multi_cycle_core: directed programs plus random ALU
// instructions, checked against an instruction-level architectural model.
module tb_multi_cycle_core;

    localparam logic [31:0] RST_PC = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        retire;
    logic [31:0] retire_pc;
    logic        halt;
    logic        trap;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    multi_cycle_core dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .retire      (retire),
        .retire_pc   (retire_pc),
        .halt        (halt),
        .trap        (trap),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          last_retire_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pc = RST_PC;
    endfunction

    // Architectural effect of one instruction, straight from the ISA definitions.
    function automatic logic [4:0] m_exec(input logic [31:0] ins);
        logic [31:0] a, b, imm_i, imm_u, imm_j, res, npc;
        logic [4:0]  rd;
        a     = m_regs[ins[19:15]];
        b     = m_regs[ins[24:20]];
        rd    = ins[11:7];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_u = {ins[31:12], 12'h000};
        imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        res   = 32'h0;
        npc   = m_pc + 32'd4;
        case (ins[6:0])
            7'h13: res = a + imm_i;
            7'h33: res = ins[30] ? a - b : a + b;
            7'h37: res = imm_u;
            7'h17: res = m_pc + imm_u;
            7'h6f: begin res = m_pc + 32'd4; npc = m_pc + imm_j; end
            7'h67: begin res = m_pc + 32'd4; npc = (a + imm_i) & 32'hFFFF_FFFE; end
            default: ;
        endcase
        if (rd != 5'd0) m_regs[rd] = res;
        m_pc = npc;
        return rd;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] r;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        r   = $urandom;
        case ($urandom_range(0, 4))
            0:       return {r[11:0], rs1, 3'b000, rd, 7'h13};
            1:       return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
            2:       return {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
            3:       return {r[19:0], rd, 7'h37};
            default: return {r[19:0], rd, 7'h17};
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("req_during_rst", 32'(imem_req), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        m_reset();
        last_retire_cyc = -1;
    endtask

    // Called in the low phase of a FETCH cycle; returns in the low phase of the next FETCH.
    task automatic run_instr(input logic [31:0] ins, input int delay);
        logic [31:0] pc0;
        logic [4:0]  rd;
        int          bad;
        pc0 = m_pc;
        bad = 0;
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, pc0);
        for (int d = 0; d < delay; d++) begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            @(negedge clk);
            if (imem_addr !== pc0 || imem_req !== 1'b1 || retire !== 1'b0) bad++;
        end
        if (delay > 0) chk("addr_hold", 32'(bad), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = ins;
        @(negedge clk);
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata  = $urandom;
        if (retire !== 1'b0 || imem_req !== 1'b0) bad++;
        @(negedge clk);
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata  = $urandom;
        if (retire !== 1'b0 || imem_req !== 1'b0) bad++;
        chk("quiet_dec_exec", 32'(bad), 32'd0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("retire", 32'(retire), 32'd1);
        chk("retire_pc", retire_pc, pc0);
        if (last_retire_cyc >= 0) chk("retire_interval", 32'(cyc - last_retire_cyc), 32'(4 + delay));
        last_retire_cyc = cyc;
        rd = m_exec(ins);
        @(negedge clk);
        dbg_addr = rd;
        #1;
        chk("dbg_rd", dbg_data, m_regs[rd]);
        $display("instr %h pc %h delay %0d rd x%0d = %h next_pc %h",
                 ins, pc0, delay, rd, dbg_data, m_pc);
    endtask

    task automatic run_halt(input logic [31:0] ins, input logic exp_trap);
        int bad;
        bad = 0;
        imem_rvalid = 1'b1;
        imem_rdata  = ins;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("halt_not_yet", 32'(halt), 32'd0);
        @(negedge clk);
        chk("halt_set", 32'(halt), 32'd1);
        chk("trap_value", 32'(trap), 32'(exp_trap));
        for (int i = 0; i < 20; i++) begin
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            @(negedge clk);
            if (imem_req !== 1'b0 || retire !== 1'b0 || halt !== 1'b1 || trap !== exp_trap) bad++;
        end
        chk("halt_absorbing", 32'(bad), 32'd0);
        $display("halt instr %h halt=%0b trap=%0b", ins, halt, trap);
    endtask

    initial begin
        rst = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        dbg_addr = 5'd0;

        // Dependent ALU chain with zero fetch latency.
        do_reset();
        run_instr(32'h00500093, 0);
        run_instr(32'h00108133, 0);
        run_instr(32'h401101B3, 0);
        dbg_addr = 5'd1; #1; chk("x1_after_chain", dbg_data, 32'd5);
        dbg_addr = 5'd2; #1; chk("x2_after_chain", dbg_data, 32'd10);
        dbg_addr = 5'd3; #1; chk("x3_after_chain", dbg_data, 32'd5);

        // Delayed fetch and a write to x0.
        do_reset();
        run_instr(32'h00500093, 0);
        run_instr(32'h00700013, 3);
        dbg_addr = 5'd0; #1; chk("x0_zero", dbg_data, 32'd0);

        // Jumps: jal, then lui + jalr with an odd target.
        do_reset();
        run_instr(32'h008000EF, 0);
        dbg_addr = 5'd1; #1; chk("jal_link", dbg_data, 32'h80000004);
        chk("jal_target", imem_addr, 32'h80000008);
        run_instr(32'h800002B7, 1);
        run_instr(32'h00328067, 0);
        chk("jalr_target", imem_addr, 32'h80000002);
        run_instr(32'h00100093, 2);

        // Random ALU traffic with random fetch latency.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            run_instr(rand_instr(), $urandom_range(0, 3));
        end

        // Reset while the second addi is in EXEC.
        do_reset();
        run_instr(32'h00900093, 0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00500093;
        @(negedge clk);
        imem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_no_retire", 32'(retire), 32'd0);
        chk("abort_req_in_rst", 32'(imem_req), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_addr", imem_addr, RST_PC);
        chk("abort_req", 32'(imem_req), 32'd1);
        dbg_addr = 5'd1; #1; chk("abort_x1", dbg_data, 32'd0);
        $display("reset during EXEC: x1=%h next fetch %h", dbg_data, imem_addr);

        // ebreak, then an illegal word after a fresh reset.
        do_reset();
        run_halt(32'h00100073, 1'b0);
        do_reset();
        run_halt(32'hFFFFFFFF, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_core.md
Name: multi_cycle_core

Overview:
Parametrised multi-cycle successor to the single-cycle addi datapath. It runs a minimal RV32I subset (addi, add, sub, lui, auipc, jal, jalr, ebreak) through a FETCH/DECODE/EXEC/WB state machine. Instruction fetch uses a req/rvalid handshake, so instruction memory may have variable latency. A debug read port and a retire pulse expose architectural state to the simulation harness.

Parameters:
XLEN, 32, datapath and register width; only 32 is supported (encodings are RV32).
RESET_PC, 32'h80000000, PC value loaded on reset.
NREGS, 32, architectural register count; x0 is hardwired to zero.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request; high throughout FETCH
imem_addr  out  XLEN  fetch address (= pc); stable while imem_req is high
imem_rvalid  in  1  fetch data valid; sampled only in FETCH
imem_rdata  in  32  instruction word
retire  out  1  one-cycle pulse in the WB cycle of each completed instruction
retire_pc  out  XLEN  PC of the retiring instruction
halt  out  1  sticky; set by ebreak or an illegal instruction
trap  out  1  sticky; set only by an illegal instruction
dbg_addr  in  5  debug register index
dbg_data  out  XLEN  combinational read of register dbg_addr (0 when dbg_addr = 0)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: pc = RESET_PC, every register = 0, state = FETCH, halt = 0, trap = 0, retire = 0. imem_req = 0 while rst is high.
- State machine:
  - FETCH: imem_req = 1. Hold until imem_rvalid; on rvalid latch the instruction into ir and go to DECODE. imem_addr must not change while waiting.
  - DECODE: read rs1/rs2, sign-extend the immediate (I/U/J formats), classify the opcode. Illegal opcode goes to HALT with trap = 1. ebreak (32'h00100073) goes to HALT with trap = 0. Otherwise go to EXEC.
  - EXEC: compute the ALU result into a register. addi = rs1 + immI; add/sub = rs1 ± rs2 (funct7[5] selects sub); lui = immU; auipc = pc + immU. For jal/jalr the result is pc + 4, and the target is pc + immJ for jal, (rs1 + immI) & ~1 for jalr. Go to WB.
  - WB: write the result to rd when rd != 0. Update pc to the target for jal/jalr, otherwise pc + 4. Assert retire with retire_pc = the old pc. Go to FETCH.
  - HALT: absorbing. imem_req = 0, halt = 1, retire = 0. Only rst leaves HALT.
- Latency: with imem_rvalid in the same cycle as req, one instruction takes exactly 4 cycles and retire pulses every 4th cycle. Each cycle of rvalid delay adds one cycle.
- Arithmetic is modulo 2^XLEN; overflow is ignored and PC wrap-around is allowed.
- Writes to x0 are discarded; reading x0 always returns 0.
- A register read in DECODE sees the WB write of the previous instruction, because WB precedes the next FETCH.
- Reset in any state, including mid-FETCH with rvalid pending: the next state is FETCH at RESET_PC, registers are cleared, and any in-flight rvalid is ignored.
- imem_rvalid outside FETCH is ignored.
- dbg_data is purely combinational and has no effect on core state.

Decomposition:
- Package core_pkg holds:
  - opcode constants: OP_IMM 7'b0010011, OP 7'b0110011, LUI 7'b0110111, AUIPC 7'b0010111, JAL 7'b1101111, JALR 7'b1100111, SYSTEM 7'b1110011;
  - the state enum {FETCH, DECODE, EXEC, WB, HALT};
  - the ALU op enum {ADD, SUB, PASSB};
  - EBREAK_INST.
- Sub-module core_regfile: parametrised by XLEN/NREGS; two combinational read ports plus the debug read port; one synchronous write port with an x0 guard; synchronous clear on rst.
- Immediate generation and the ALU stay inline.

Test Plan:
- Reset: hold rst 2 cycles, then release → first cycle after release has imem_req = 1, imem_addr = 32'h80000000; halt = 0, retire = 0.
- addi x1,x0,5 (32'h00500093), then add x2,x1,x1 (32'h00108133), then sub x3,x2,x1 (32'h401101B3), rvalid with zero delay → retire on cycles 4, 8, 12; dbg reads x1 = 5, x2 = 10, x3 = 5; retire_pc = 0x80000000 / 04 / 08.
- rvalid delayed 3 cycles on the second fetch → imem_addr held at 0x80000004 throughout, retire interval 7 cycles; addi x0,x0,7 (32'h00700013) leaves dbg x0 = 0.
- jal x1,+8 (32'h008000EF) at 0x80000000 → x1 = 0x80000004, next fetch 0x80000008. lui x5,0x80000 (32'h800002B7) then jalr x0,3(x5) → next fetch 0x80000002 (bit 0 cleared).
- ebreak (32'h00100073) → halt = 1, trap = 0, imem_req stays 0 for 20 cycles. Fresh reset, then 32'hFFFFFFFF → halt = 1, trap = 1, no retire.
- Assert rst during EXEC of addi x1,x0,5 → x1 = 0, next imem_addr = 0x80000000, no retire pulse for the aborted instruction.
